// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the baud divisor.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Rounded clocks-per-bit; 217 for 25 MHz / 115200.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head data is combinational from storage, zero while empty.
// A write while full is ignored unless a read frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_rd;
  logic             do_wr;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign level  = wptr - rptr;
  assign rd_vld = (wptr != rptr);
  assign full   = (level == (AW+1)'(DEPTH));
  assign do_rd  = rd_vld & rd_rdy;
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = rd_vld ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_dat;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop synchroniser, mid-bit sampling) buffering {perr, data} in a FWFT FIFO.
// m_valid rises one cycle after the last stop sample; a full FIFO drops the character and pulses overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_perr,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);
  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV + 1);
  // Expiry is the cycle the counter sits at zero, so a reload of DIV-1 spaces samples DIV apart.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rxs;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 par_exp;
  logic                 tick;
  logic                 push_vld;
  logic [8:0]           push_dat;
  logic [8:0]           head_dat;
  logic                 fifo_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick    = (baud_cnt == '0);
  assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      frame_err <= 1'b0;
    end else begin
      push_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && !en) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        if (!tick) baud_cnt <= baud_cnt - 1'b1;
        case (state)
          IDLE: begin
            if (en && !rxs) begin
              baud_cnt <= CNT_HALF;
              state    <= START;
            end
          end
          START: begin
            if (tick) begin
              if (!rxs) begin
                baud_cnt <= CNT_BIT;
                bit_cnt  <= '0;
                perr     <= 1'b0;
                state    <= DATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            if (tick) begin
              shreg    <= {rxs, shreg[DATA_BITS-1:1]};
              baud_cnt <= CNT_BIT;
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          uart_pkg::PARITY: begin
            if (tick) begin
              perr     <= rxs ^ par_exp;
              baud_cnt <= CNT_BIT;
              state    <= STOP;
            end
          end
          STOP: begin
            if (tick) begin
              baud_cnt <= CNT_BIT;
              if (!rxs) begin
                frame_err <= 1'b1;
                bit_cnt   <= '0;
                state     <= WAIT_IDLE;
              end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                push_vld <= 1'b1;
                push_dat <= {perr, 8'(shreg)};
                bit_cnt  <= '0;
                state    <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WAIT_IDLE: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (m_ready),
    .rd_vld (m_valid),
    .rd_dat (head_dat),
    .full   (fifo_full),
    .level  (level)
  );

  assign m_data = head_dat[7:0];
  assign m_perr = head_dat[8];

  // A same-cycle pop makes room, so only an unrelieved full drops the character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= push_vld & fifo_full & ~(m_valid & m_ready);
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8N1 default instance plus an even-parity instance.
module tb_uart_rx_fifo;
  localparam int DIV = 217;
  localparam int LW  = 5;

  logic          clk_25m = 1'b0;
  logic          reset, rxd, en, m_ready;
  logic          m_valid, m_perr, frame_err, overflow, busy;
  logic [7:0]    m_data;
  logic [LW-1:0] level;
  logic          rxd_p, en_p, m_ready_p;
  logic          m_valid_p, m_perr_p, frame_err_p, overflow_p, busy_p;
  logic [7:0]    m_data_p;
  logic [LW-1:0] level_p;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_cnt_p = 0;
  logic [8:0] sbq[$];
  logic [8:0] sbq_p[$];

  uart_rx_fifo dut (
    .clock(clk_25m), .reset(reset), .rxd(rxd), .en(en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr),
    .frame_err(frame_err), .overflow(overflow), .level(level), .busy(busy)
  );

  uart_rx_fifo #(.PARITY(2)) dut_p (
    .clock(clk_25m), .reset(reset), .rxd(rxd_p), .en(en_p),
    .m_valid(m_valid_p), .m_ready(m_ready_p), .m_data(m_data_p), .m_perr(m_perr_p),
    .frame_err(frame_err_p), .overflow(overflow_p), .level(level_p), .busy(busy_p)
  );

  always #20 clk_25m = ~clk_25m;
  always @(posedge clk_25m) cyc <= cyc + 1;
  always @(negedge clk_25m) begin
    if (frame_err)   fe_cnt++;
    if (overflow)    ov_cnt++;
    if (frame_err_p) fe_cnt_p++;
  end

  task automatic line_set(input bit to_p, input logic v);
    if (to_p) rxd_p = v;
    else      rxd   = v;
  endtask

  task automatic bit_time();
    repeat (DIV) @(posedge clk_25m);
    #1;
  endtask

  // par_bit < 0 means no parity bit on the line.
  task automatic send_char(input bit to_p, input logic [7:0] d, input int par_bit, input logic stop_v);
    line_set(to_p, 1'b0);
    bit_time();
    for (int i = 0; i < 8; i++) begin
      line_set(to_p, d[i]);
      bit_time();
    end
    if (par_bit >= 0) begin
      line_set(to_p, par_bit[0]);
      bit_time();
    end
    line_set(to_p, stop_v);
    bit_time();
    line_set(to_p, 1'b1);
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    @(posedge clk_25m);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; rxd = 1'b1; m_ready = 1'b0;
    en_p = 1'b0; rxd_p = 1'b1; m_ready_p = 1'b0;
    repeat (3) @(posedge clk_25m);
    #1;
    n_vec++;
    if ({m_valid, m_perr, frame_err, overflow, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, expected 00000", {m_valid, m_perr, frame_err, overflow, busy});
    end
    n_vec++;
    if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, expected 00", m_data); end
    n_vec++;
    if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d, expected 0", level); end
    n_vec++;
    if ({m_valid_p, m_perr_p, frame_err_p, overflow_p, busy_p, level_p, m_data_p} !== 18'b0) begin
      n_err++; $display("FAIL reset_par_dut: got %h, expected 0", {m_valid_p, m_perr_p, frame_err_p, overflow_p, busy_p, level_p, m_data_p});
    end
    reset = 1'b0; en = 1'b1; en_p = 1'b1;
    repeat (4) @(posedge clk_25m);
    #1;
  endtask

  task automatic test_basic();
    int c0, rise, fe0;
    logic [8:0] exp;
    fe0 = fe_cnt; rise = -1; c0 = cyc;
    sbq.push_back({1'b0, 8'hA5});
    fork
      send_char(1'b0, 8'hA5, -1, 1'b1);
      for (int i = 0; i < 2300 && rise < 0; i++) begin
        @(negedge clk_25m);
        if (m_valid) rise = cyc - c0;
      end
    join
    // Ideal stop-bit centre at 9.5 bits (2061) plus synchroniser and push cycles.
    n_vec++;
    if (rise < 2058 || rise > 2072) begin n_err++; $display("FAIL basic_latency: got %0d cycles, expected 2058..2072", rise); end
    exp = sbq.pop_front();
    n_vec++;
    if (!m_valid || {m_perr, m_data} !== exp) begin n_err++; $display("FAIL basic_data: got v=%b %h, expected 1 %h", m_valid, {m_perr, m_data}, exp); end
    n_vec++;
    if (level !== 5'd1) begin n_err++; $display("FAIL basic_level: got %0d, expected 1", level); end
    pop_one();
    n_vec++;
    if (level !== 5'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop: got level %0d valid %b, expected 0 0", level, m_valid); end
    n_vec++;
    if (fe_cnt != fe0) begin n_err++; $display("FAIL basic_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_parity();
    logic [8:0] exp;
    int fe0;
    fe0 = fe_cnt_p;
    sbq_p.push_back({1'b1, 8'h03});
    send_char(1'b1, 8'h03, 1, 1'b1);
    sbq_p.push_back({1'b0, 8'h07});
    send_char(1'b1, 8'h07, 1, 1'b1);
    n_vec++;
    if (level_p !== 5'd2) begin n_err++; $display("FAIL parity_level: got %0d, expected 2", level_p); end
    n_vec++;
    if (fe_cnt_p != fe0) begin n_err++; $display("FAIL parity_frame_err: got %0d pulses, expected 0", fe_cnt_p - fe0); end
    for (int k = 0; k < 2; k++) begin
      exp = sbq_p.pop_front();
      n_vec++;
      if (!m_valid_p || {m_perr_p, m_data_p} !== exp) begin
        n_err++; $display("FAIL parity_entry%0d: got v=%b %h, expected 1 %h", k, m_valid_p, {m_perr_p, m_data_p}, exp);
      end
      m_ready_p = 1'b1;
      @(posedge clk_25m);
      #1;
      m_ready_p = 1'b0;
    end
  endtask

  task automatic test_framing();
    int fe0;
    logic [LW-1:0] lvl0;
    logic [8:0] exp;
    fe0 = fe_cnt; lvl0 = level;
    send_char(1'b0, 8'h00, -1, 1'b0);
    line_set(1'b0, 1'b0);
    repeat (20) bit_time();
    n_vec++;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL framing_pulses: got %0d, expected 1", fe_cnt - fe0); end
    n_vec++;
    if (level !== lvl0) begin n_err++; $display("FAIL framing_level: got %0d, expected %0d", level, lvl0); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL framing_busy_low: got %b, expected 1", busy); end
    line_set(1'b0, 1'b1);
    repeat (10) @(posedge clk_25m);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL framing_busy_idle: got %b, expected 0", busy); end
    sbq.push_back({1'b0, 8'h55});
    send_char(1'b0, 8'h55, -1, 1'b1);
    exp = sbq.pop_front();
    n_vec++;
    if (!m_valid || {m_perr, m_data} !== exp) begin n_err++; $display("FAIL framing_recover: got v=%b %h, expected 1 %h", m_valid, {m_perr, m_data}, exp); end
    pop_one();
    n_vec++;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL framing_total: got %0d pulses, expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_overflow();
    int ov0;
    logic [7:0] cb;
    logic [8:0] exp;
    ov0 = ov_cnt;
    m_ready = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      cb = 8'(c);
      if (c <= 16) sbq.push_back({1'b0, cb});
      send_char(1'b0, cb, -1, 1'b1);
      if (c == 16) begin
        n_vec++;
        if (level !== 5'd16 || ov_cnt != ov0) begin
          n_err++; $display("FAIL ovf_fill: got level %0d pulses %0d, expected 16 0", level, ov_cnt - ov0);
        end
      end
    end
    n_vec++;
    if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d, expected 16", level); end
    n_vec++;
    if (ov_cnt - ov0 != 1) begin n_err++; $display("FAIL ovf_pulses: got %0d, expected 1", ov_cnt - ov0); end
    for (int k = 0; k < 16; k++) begin
      exp = sbq.pop_front();
      n_vec++;
      if (!m_valid || {m_perr, m_data} !== exp) begin
        n_err++; $display("FAIL ovf_drain%0d: got v=%b %h, expected 1 %h", k, m_valid, {m_perr, m_data}, exp);
      end
      pop_one();
    end
    n_vec++;
    if (level !== 5'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got level %0d valid %b, expected 0 0", level, m_valid); end
  endtask

  task automatic test_glitch();
    int fe0, ov0, dur;
    logic [LW-1:0] lvl0;
    logic rose;
    fe0 = fe_cnt; ov0 = ov_cnt; lvl0 = level; dur = 0; rose = 1'b0;
    fork
      begin
        line_set(1'b0, 1'b0);
        repeat (DIV / 4) @(posedge clk_25m);
        #1;
        line_set(1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 20 && !rose; i++) begin
          @(negedge clk_25m);
          rose = busy;
        end
        if (rose) begin
          for (int i = 0; i < 400 && busy; i++) begin
            @(negedge clk_25m);
            dur++;
          end
        end
      end
    join
    n_vec++;
    if (!rose || busy !== 1'b0 || dur > DIV / 2 + 3) begin
      n_err++; $display("FAIL glitch_busy: got rose %b busy %b after %0d cycles, expected idle within %0d", rose, busy, dur, DIV / 2 + 3);
    end
    repeat (2 * DIV) @(posedge clk_25m);
    #1;
    n_vec++;
    if (level !== lvl0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      n_err++; $display("FAIL glitch_side_effects: got level %0d fe %0d ov %0d, expected %0d 0 0", level, fe_cnt - fe0, ov_cnt - ov0, lvl0);
    end
  endtask

  task automatic test_en_drop();
    int fe0;
    logic [LW-1:0] lvl0;
    fe0 = fe_cnt; lvl0 = level;
    fork
      send_char(1'b0, 8'h5A, -1, 1'b1);
      begin
        repeat (4 * DIV) @(posedge clk_25m);
        #1;
        en = 1'b0;
        @(posedge clk_25m);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL en_drop_busy: got %b, expected 0", busy); end
      end
    join
    en = 1'b1;
    repeat (DIV) @(posedge clk_25m);
    #1;
    n_vec++;
    if (level !== lvl0 || fe_cnt != fe0) begin
      n_err++; $display("FAIL en_drop_discard: got level %0d fe %0d, expected %0d 0", level, fe_cnt - fe0, lvl0);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    sbq.push_back({1'b0, 8'h11});
    send_char(1'b0, 8'h11, -1, 1'b1);
    n_vec++;
    if (level !== 5'd1) begin n_err++; $display("FAIL rstmid_prefill: got %0d, expected 1", level); end
    fork
      send_char(1'b0, 8'h99, -1, 1'b1);
      begin
        repeat (4 * DIV + DIV / 2) @(posedge clk_25m);
        #1;
        reset = 1'b1;
        @(negedge clk_25m);
        n_vec++;
        if ({m_valid, m_perr, frame_err, overflow, busy, level, m_data} !== 18'b0) begin
          n_err++; $display("FAIL rstmid_outputs: got %h, expected 0", {m_valid, m_perr, frame_err, overflow, busy, level, m_data});
        end
      end
    join
    sbq.delete();
    sbq_p.delete();
    reset = 1'b0;
    repeat (4) @(posedge clk_25m);
    #1;
    sbq.push_back({1'b0, 8'h3C});
    send_char(1'b0, 8'h3C, -1, 1'b1);
    exp = sbq.pop_front();
    n_vec++;
    if (!m_valid || {m_perr, m_data} !== exp || level !== 5'd1) begin
      n_err++; $display("FAIL rstmid_after: got v=%b %h level %0d, expected 1 %h level 1", m_valid, {m_perr, m_data}, level, exp);
    end
    pop_one();
  endtask

  initial begin
    #(80000 * 40);
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overflow();
    test_glitch();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable, parametrised UART receiver with an integrated receive FIFO. It is the on-chip successor to the fixed 115200-baud 8N1 behavioural tty model. Baud rate, character width, parity and stop bits are compile-time parameters. Received characters are buffered in a FIFO with per-entry parity status, and framing and overflow errors are reported as pulses. It sits behind the SoC UART pad and feeds a valid/ready consumer, either the bus register block or a testbench scoreboard.

Parameters:
CLK_HZ, 25000000, clock frequency in Hz
BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD, which is 217 at the defaults
DATA_BITS, 8, character width, legal range 5..8, LSB first on the line
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, number of entries; must be a power of 2 and ≥2

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-high reset
rxd  in  1  serial line, idle-high, asynchronous to clock
en  in  1  receiver enable
m_valid  out  1  FIFO head is valid
m_ready  in  1  consumer accepts the head
m_data  out  8  head character, zero-extended above DATA_BITS
m_perr  out  1  parity error flag of the head entry; 0 when PARITY = 0
frame_err  out  1  one-cycle pulse: stop bit sampled low
overflow  out  1  one-cycle pulse: character dropped because the FIFO was full
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - all outputs are 0
  - the 2-flop rxd synchroniser resets to 1
  - FSM in IDLE, FIFO empty, bit and baud counters 0
- Synchroniser: rxd passes through 2 flops; all FSM decisions use the synchronised value (rxs).
- FSM states and transitions:
  - IDLE: if en=1 and rxs=0, load baud counter with DIV/2 and go to START.
  - START: when the counter expires, sample rxs. If 0, go to DATA with the counter loaded to DIV. If 1, it is a false start (glitch): return to IDLE, nothing is pushed, no error is raised.
  - DATA: sample one bit at each expiry of DIV; shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: sample the parity bit. perr = 1 if the sampled bit mismatches the computed odd/even parity of the data.
  - STOP: sample the stop bit(s); with STOP_BITS=2, both are sampled, DIV apart. If every stop sample is 1, push {perr, data} and go to IDLE. If any stop sample is 0, pulse frame_err, push nothing, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1 (break or line held low), then go to IDLE.
- Push latency: m_valid rises 1 cycle after the final stop-bit sample when the FIFO was empty.
- FIFO: first-word-fall-through; m_data and m_perr are valid whenever m_valid=1. A pop occurs on m_valid & m_ready.
- Full FIFO: a push pulses overflow, drops the new character, and leaves the FIFO contents and level unchanged.
- Full FIFO with a push and a pop in the same cycle: the pop frees a slot first, so the push is accepted, no overflow occurs, and level is unchanged.
- Empty FIFO: m_valid=0, and m_ready is ignored.
- Pointers: read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally; level = wptr − rptr.
- en deasserted mid-frame: the FSM returns to IDLE on the next cycle and the partial character is discarded with no error pulse. FIFO contents are retained and pops still work.
- Reset asserted mid-frame: every register returns to its reset value immediately (asynchronous). After release, the receiver waits for a fresh falling edge.

Decomposition:
- Package uart_pkg holds:
  - parity encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN)
  - the rx FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - a constant function computing DIV from CLK_HZ and BAUD
- Sub-module sync_fifo (parameters WIDTH, DEPTH) is natural. It provides push/pop/full/empty/level and is reusable by a future transmitter.

Test Plan:
- Defaults (8N1, DIV=217): send 0xA5 -> m_valid rises 1 cycle after the stop-bit sample, m_data=0xA5, m_perr=0, level=1; pop -> level=0.
- PARITY=2, send 0x03 with parity bit 1 (correct value is 0) -> entry m_data=0x03, m_perr=1, frame_err stays 0.
- Stop bit driven 0, then rxd held low for 20 bit times -> exactly one frame_err pulse, level unchanged, busy=1 until rxd returns high, then a following 0x55 is received correctly.
- m_ready=0, send 17 characters 0x01..0x11 -> level=16, one overflow pulse on the 17th; the drain order is 0x01..0x10.
- rxd low for DIV/4 cycles only -> no push, no error pulse, busy returns to 0 within DIV/2+3 cycles.
- Reset asserted during data bit 3, released, then 0x3C sent -> all outputs 0 during reset; afterwards m_data=0x3C with level=1.
